// File: rtl/unibus_pkg.sv
// Shared types and constants for the Unibus arbiter and its bus watchdog.
package unibus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_ACK,
        ARB_BUSY
    } arb_state_t;

    localparam int unsigned DEF_NREQ     = 4;
    localparam int unsigned DEF_GRANT_TO = 64;
    localparam int unsigned DEF_BUS_TO   = 512;
    localparam int unsigned MAX_REQ      = 16;

    // Lowest set bit as a one-hot vector (index 0 = highest priority).
    function automatic logic [MAX_REQ-1:0] prio_onehot(input logic [MAX_REQ-1:0] r);
        return r & (~r + 1'b1);
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// No-SSYN bus watchdog: flags a bus cycle whose MSYN goes unanswered for too long.
module bus_watchdog
    import unibus_pkg::*;
#(
    parameter int unsigned BUS_TO = DEF_BUS_TO
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic msyn,
    input  logic ssyn,
    output logic timeout
);

    localparam int unsigned   CW    = $clog2(BUS_TO) + 1;
    localparam logic [CW-1:0] LIMIT = CW'(BUS_TO - 1);

    logic [CW-1:0] count;

    // Once raised, the flag survives a late SSYN and only clears with MSYN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            timeout <= 1'b0;
        end else if (clear || !msyn) begin
            count   <= '0;
            timeout <= 1'b0;
        end else if (ssyn) begin
            count <= '0;
        end else begin
            if (count != LIMIT) begin
                count <= count + 1'b1;
            end
            if (count + 1'b1 >= LIMIT) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/unibus_arbiter.sv
// Unibus mastership arbiter: fixed-priority grant/SACK/BBSY handshake plus bus watchdog.
module unibus_arbiter
    import unibus_pkg::*;
#(
    parameter int unsigned NREQ     = DEF_NREQ,
    parameter int unsigned GRANT_TO = DEF_GRANT_TO,
    parameter int unsigned BUS_TO   = DEF_BUS_TO
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            bus_init,
    input  logic            cpu_busy,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] sack,
    output logic [NREQ-1:0] grant,
    input  logic            bus_bbsy,
    output logic            dma_owner,
    input  logic            bus_msyn,
    input  logic            bus_ssyn,
    output logic            bus_timeout
);

    localparam int unsigned   GCW       = $clog2(GRANT_TO) + 1;
    localparam logic [GCW-1:0] GCNT_LAST = GCW'(GRANT_TO - 1);

    arb_state_t      state, state_n;
    logic [NREQ-1:0] winner, winner_n;
    logic [NREQ-1:0] grant_n;
    logic [GCW-1:0]  gcnt, gcnt_n;
    logic            owner_n;

    logic [MAX_REQ-1:0] req_ext;
    logic [MAX_REQ-1:0] pick;
    logic               unused_pick_hi;
    logic               sacked;

    always_comb begin
        req_ext           = '0;
        req_ext[NREQ-1:0] = req;
    end

    assign pick           = prio_onehot(req_ext);
    assign unused_pick_hi = ^pick;
    assign sacked         = |(sack & winner);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ARB_IDLE;
            winner    <= '0;
            gcnt      <= '0;
            grant     <= '0;
            dma_owner <= 1'b0;
        end else if (bus_init) begin
            state     <= ARB_IDLE;
            winner    <= '0;
            gcnt      <= '0;
            grant     <= '0;
            dma_owner <= 1'b0;
        end else begin
            state     <= state_n;
            winner    <= winner_n;
            gcnt      <= gcnt_n;
            grant     <= grant_n;
            dma_owner <= owner_n;
        end
    end

    always_comb begin
        state_n  = state;
        winner_n = winner;
        gcnt_n   = gcnt;
        grant_n  = grant;
        owner_n  = dma_owner;

        unique case (state)
            ARB_IDLE: begin
                gcnt_n = '0;
                if (|req && !cpu_busy && !bus_bbsy) begin
                    winner_n = pick[NREQ-1:0];
                    grant_n  = pick[NREQ-1:0];
                    state_n  = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                // SACK is honoured even on the final counted cycle.
                if (sacked) begin
                    grant_n = '0;
                    owner_n = 1'b1;
                    state_n = ARB_ACK;
                end else if (gcnt == GCNT_LAST) begin
                    grant_n = '0;
                    state_n = ARB_IDLE;
                end else begin
                    gcnt_n = gcnt + 1'b1;
                end
            end
            ARB_ACK: begin
                if (!sacked) begin
                    if (bus_bbsy) begin
                        state_n = ARB_BUSY;
                    end else begin
                        owner_n = 1'b0;
                        state_n = ARB_IDLE;
                    end
                end
            end
            ARB_BUSY: begin
                if (!bus_bbsy) begin
                    owner_n = 1'b0;
                    state_n = ARB_IDLE;
                end
            end
            default: begin
                grant_n = '0;
                owner_n = 1'b0;
                state_n = ARB_IDLE;
            end
        endcase
    end

    bus_watchdog #(
        .BUS_TO(BUS_TO)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (bus_init),
        .msyn   (bus_msyn),
        .ssyn   (bus_ssyn),
        .timeout(bus_timeout)
    );

endmodule
